cache_refill: RTL and testbench

Miss handler for the 2-way set-associative instruction/data cache. When the cache reports a miss, the block fetches the whole line from main memory one word at a time and assembles it. It selects a victim way from the set's valid/used metadata and issues a single write into the cache RAM. It sits between the cache lookup stage (upstream, which raises the miss) and the main-memory port (downstream).

---
 rtl/cache_refill_pkg.sv | 17 +
 rtl/cache_refill_if.sv | 45 ++++
 rtl/cache_refill_line_buffer.sv | 40 ++++
 rtl/cache_refill.sv | 103 ++++++++++
 tb/tb_cache_refill.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_pkg.sv
// Shared parameters and FSM encoding for the cache refill path.
// Used by the refill block and by the cache that instantiates it.
package cache_refill_pkg;

    localparam int EC_DEF = 13;
    localparam int EW_DEF = 2;
    localparam int ES_DEF = EC_DEF - EW_DEF - 1;
    localparam int A_DEF  = 32;
    localparam int D_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/cache_refill_if.sv
// Bundle of lookup-stage, main-memory and cache-write signals around the refill block.
// The refill block is the master; the surrounding cache/memory system is the slave.
interface cache_refill_if
    import cache_refill_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int D  = D_DEF,
    parameter int eS = ES_DEF,
    parameter int ew = EW_DEF
);
    localparam int tagSize   = A - eS - ew;
    localparam int entrySize = D << ew;

    logic                 miss_req;
    logic [A-1:0]         miss_addr;
    logic                 meta_used;
    logic                 meta_valid0;
    logic                 meta_valid1;
    logic                 busy;
    logic                 done;
    logic [A-1:0]         mem_addr;
    logic                 mem_re;
    logic                 mem_ack;
    logic [D-1:0]         mem_rdata;
    logic                 wr_en;
    logic [eS-1:0]        wr_set;
    logic                 wr_way;
    logic [tagSize-1:0]   wr_tag;
    logic [entrySize-1:0] wr_line;

    modport master (
        input  miss_req, miss_addr, meta_used, meta_valid0, meta_valid1,
        input  mem_ack, mem_rdata,
        output busy, done, mem_addr, mem_re,
        output wr_en, wr_set, wr_way, wr_tag, wr_line
    );

    modport slave (
        output miss_req, miss_addr, meta_used, meta_valid0, meta_valid1,
        output mem_ack, mem_rdata,
        input  busy, done, mem_addr, mem_re,
        input  wr_en, wr_set, wr_way, wr_tag, wr_line
    );

endinterface

// File: rtl/cache_refill_line_buffer.sv
// Line assembly register: one D-bit word per slot, written by word index.
// Reset clears the whole line so an aborted refill leaves nothing behind.
module line_buffer #(
    parameter int D  = 16,
    parameter int ew = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ew-1:0]       idx,
    input  logic [D-1:0]        data,
    output logic [(D<<ew)-1:0]  line
);

    genvar gi;
    generate
        for (gi = 0; gi < (1 << ew); gi++) begin : g_word
            logic [D-1:0] word_q;
            logic [D-1:0] word_d;

            always_comb begin
                word_d = word_q;
                if (we && (idx == ew'(gi))) begin
                    word_d = data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign line[gi*D +: D] = word_q;
        end
    endgenerate

endmodule

// File: rtl/cache_refill.sv
// Miss handler for the 2-way cache: fetches a line word by word in aligned order,
// picks a victim way and issues one write into the cache RAM.
module cache_refill
    import cache_refill_pkg::*;
#(
    parameter int eC = EC_DEF,
    parameter int ew = EW_DEF,
    parameter int eS = eC - ew - 1,
    parameter int A  = A_DEF,
    parameter int D  = D_DEF
) (
    input  logic           clk,
    input  logic           rst,
    cache_refill_if.master bus
);

    localparam int tagSize   = A - eS - ew;
    localparam int entrySize = D << ew;

    state_t               state_q, state_d;
    logic [tagSize-1:0]   tag_q, tag_d;
    logic [eS-1:0]        set_q, set_d;
    logic [ew-1:0]        cnt_q, cnt_d;
    logic                 way_q, way_d;
    logic                 buf_we;
    logic [entrySize-1:0] line;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        set_d   = set_q;
        cnt_d   = cnt_q;
        way_d   = way_q;
        buf_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.miss_req) begin
                    tag_d   = bus.miss_addr[A-1 -: tagSize];
                    set_d   = bus.miss_addr[ew +: eS];
                    // Fill an empty way first; otherwise evict the least recently used one.
                    way_d   = bus.meta_valid0 ? (bus.meta_valid1 ? ~bus.meta_used : 1'b1) : 1'b0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            set_q   <= '0;
            cnt_q   <= '0;
            way_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
        end
    end

    line_buffer #(
        .D  (D),
        .ew (ew)
    ) u_line_buffer (
        .clk  (clk),
        .rst  (rst),
        .we   (buf_we),
        .idx  (cnt_q),
        .data (bus.mem_rdata),
        .line (line)
    );

    // All outputs come from flops or the state register, never from mem_ack.
    assign bus.busy     = (state_q != IDLE);
    assign bus.mem_re   = (state_q == FETCH);
    assign bus.wr_en    = (state_q == WRITE);
    assign bus.done     = (state_q == WRITE);
    assign bus.mem_addr = {tag_q, set_q, cnt_q};
    assign bus.wr_set   = set_q;
    assign bus.wr_way   = way_q;
    assign bus.wr_tag   = tag_q;
    assign bus.wr_line  = line;

endmodule

// File: tb/tb_cache_refill.sv
// Scoreboard bench for cache_refill: randomized misses and memory wait states,
// expected cache writes computed from address arithmetic and a memory content function.
module tb_cache_refill;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_refill_if #(.A(32), .D(16), .eS(10), .ew(2)) bus ();

    cache_refill #(.eC(13), .ew(2), .A(32), .D(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0]  set;
        logic [19:0] tag;
        logic        way;
        logic [63:0] line;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    int          wq[$];
    logic [31:0] aq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          n_wr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Main-memory contents: words 0x1234..0x1237 read as 0xA000..0xA003.
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return (a[15:0] + 16'h8DCC) ^ a[31:16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cache write is matched against the oldest expected refill.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.wr_en) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got wr_en=1 expected no write (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("wr_set",  64'(bus.wr_set),  64'(e.set));
                    chk("wr_tag",  64'(bus.wr_tag),  64'(e.tag));
                    chk("wr_way",  64'(bus.wr_way),  64'(e.way));
                    chk("wr_line", bus.wr_line, e.line);
                    chk("done",    64'(bus.done), 64'd1);
                    chk("mem_re_in_write", 64'(bus.mem_re), 64'd0);
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    n_wr++;
                    $display("write %0d: set=%h tag=%h way=%0d line=%h cycle=%0d",
                             n_wr, bus.wr_set, bus.wr_tag, bus.wr_way, bus.wr_line, cyc);
                end
            end
        end
    end

    // Memory responder: per-word wait counts come from wq, expected addresses from aq.
    initial begin : memory
        int          w;
        bit          have;
        bit          nack;
        logic [31:0] last;
        have = 1'b0;
        nack = 1'b0;
        w    = 0;
        last = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (rst) begin
                have = 1'b0;
                nack = 1'b0;
            end else if (bus.mem_re) begin
                if (nack) chk("mem_addr_stable", 64'(bus.mem_addr), 64'(last));
                if (!have) begin
                    w    = (wq.size() > 0) ? wq.pop_front() : 0;
                    have = 1'b1;
                end
                if (w > 0) begin
                    w--;
                    nack = 1'b1;
                    last = bus.mem_addr;
                end else begin
                    have = 1'b0;
                    nack = 1'b0;
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    if (aq.size() > 0) begin
                        chk("mem_addr", 64'(bus.mem_addr), 64'(aq.pop_front()));
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_fetch: got mem_addr=%h expected no read", bus.mem_addr);
                    end
                end
            end else begin
                nack = 1'b0;
                // Stray acks while not reading must be ignored by the DUT.
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
            end
        end
    end

    task automatic wait_idle(input string name);
        int guard = 0;
        while (bus.busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got busy=1 after %0d cycles expected idle", name, guard);
        end
    endtask

    // Issue one miss at the current (idle) negedge and push its expected write.
    task automatic do_refill(input logic [31:0] addr, input bit v0, input bit v1,
                             input bit used, input int wmode, input bit hold);
        exp_t        e;
        int          tot;
        int          w;
        int          guard;
        logic [31:0] wa;
        tot = 0;
        wait_idle("idle_before_req");
        bus.miss_req    = 1'b1;
        bus.miss_addr   = addr;
        bus.meta_valid0 = v0;
        bus.meta_valid1 = v1;
        bus.meta_used   = used;
        e.set  = 10'((addr >> 2) % 1024);
        e.tag  = 20'(addr >> 12);
        e.way  = !v0 ? 1'b0 : (!v1 ? 1'b1 : !used);
        e.line = '0;
        for (int i = 0; i < 4; i++) begin
            wa = (addr & ~32'h3) + 32'(i);
            aq.push_back(wa);
            e.line[i*16 +: 16] = mem_word(wa);
            w = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
            wq.push_back(w);
            tot += w;
        end
        e.cyc = cyc + 5 + tot;
        expq.push_back(e);
        @(negedge clk);
        chk("accept_busy", 64'(bus.busy), 64'd1);
        chk("accept_mem_re", 64'(bus.mem_re), 64'd1);
        if (!hold) bus.miss_req = 1'b0;
        guard = 0;
        while (bus.busy && guard < 400) begin
            if (hold) begin
                bus.miss_addr   = $urandom;
                bus.meta_valid0 = 1'($urandom_range(0, 1));
                bus.meta_valid1 = 1'($urandom_range(0, 1));
                bus.meta_used   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL refill_timeout: got busy=1 after %0d cycles expected idle", guard);
        end
    endtask

    initial begin : stimulus
        logic [31:0] a;
        bus.miss_req    = 1'b0;
        bus.miss_addr   = '0;
        bus.meta_used   = 1'b0;
        bus.meta_valid0 = 1'b0;
        bus.meta_valid1 = 1'b0;

        #1;
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_done",     64'(bus.done),     64'd0);
        chk("rst_mem_re",   64'(bus.mem_re),   64'd0);
        chk("rst_wr_en",    64'(bus.wr_en),    64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_wr_set",   64'(bus.wr_set),   64'd0);
        chk("rst_wr_way",   64'(bus.wr_way),   64'd0);
        chk("rst_wr_tag",   64'(bus.wr_tag),   64'd0);
        chk("rst_wr_line",  bus.wr_line,       64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_refill(32'h0000_1236, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_refill($urandom, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        do_refill($urandom, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        do_refill($urandom, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        do_refill($urandom, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        do_refill($urandom, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        do_refill($urandom, 1'b1, 1'b1, 1'b1, 0, 1'b0);

        // Abort after the second word has been taken.
        wait_idle("idle_before_abort");
        a = 32'hDEAD_BEE9;
        bus.miss_req    = 1'b1;
        bus.miss_addr   = a;
        bus.meta_valid0 = 1'b1;
        bus.meta_valid1 = 1'b1;
        bus.meta_used   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wq.push_back(0);
            aq.push_back((a & ~32'h3) + 32'(i));
        end
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_mem_re",  64'(bus.mem_re),  64'd0);
        chk("abort_busy",    64'(bus.busy),    64'd0);
        chk("abort_wr_en",   64'(bus.wr_en),   64'd0);
        chk("abort_wr_line", bus.wr_line,      64'd0);
        chk("abort_words_fetched", 64'(aq.size()), 64'd2);
        bus.miss_req = 1'b0;
        wq.delete();
        aq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_refill(a, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            do_refill($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end
        bus.miss_req = 1'b0;

        for (int g = 0; g < 50 && expq.size() > 0; g++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("pending_writes", 64'(expq.size()), 64'd0);
        chk("busy_at_end", 64'(bus.busy), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "simulation time limit");
    end

endmodule
